// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential signed multiply/divide unit with HI/LO registers
// Works on magnitudes that are WIDTH+1 bits wide, then applies sign correction in the FIX state.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             flush,
    input  logic             mf_req,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             dz
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d, acc_q, acc_d;
    logic [WIDTH-1:0] qp_q, qp_d, hi_q, hi_d, lo_q, lo_d;
    logic             op_div_q, op_div_d, neg_q, neg_d, sign_a_q, sign_a_d, dz_q, dz_d;

    logic             can_start;
    logic [WIDTH:0]   a_ext, b_ext, a_mag_new, b_mag_new, add_sum, trial, sub_diff;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, a_orig;

    always_comb begin
        a_ext     = {src_a[WIDTH-1], src_a};
        b_ext     = {src_b[WIDTH-1], src_b};
        a_mag_new = src_a[WIDTH-1] ? -a_ext : a_ext;
        b_mag_new = src_b[WIDTH-1] ? -b_ext : b_ext;
        can_start = (state_q == S_IDLE || state_q == S_DONE) && (start_mult || start_div) && !flush;

        // Mult: acc:qp is the partial product, qp also shifts the multiplier out.
        add_sum   = acc_q + (qp_q[0] ? a_mag_q : '0);
        // Div: acc is the partial remainder, qp shifts the dividend out and the quotient in.
        trial     = {acc_q[WIDTH-1:0], qp_q[WIDTH-1]};
        sub_diff  = trial - b_mag_q;

        prod_mag  = {acc_q[WIDTH-1:0], qp_q};
        prod_fix  = neg_q ? -prod_mag : prod_mag;
        quo_fix   = neg_q ? -qp_q : qp_q;
        rem_fix   = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        a_orig    = sign_a_q ? -a_mag_q[WIDTH-1:0] : a_mag_q[WIDTH-1:0];

        state_d  = state_q;
        count_d  = count_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        qp_d     = qp_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        op_div_d = op_div_q;
        neg_d    = neg_q;
        sign_a_d = sign_a_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (can_start) begin
                    state_d  = S_ITER;
                    count_d  = '0;
                    op_div_d = !start_mult;
                    a_mag_d  = a_mag_new;
                    b_mag_d  = b_mag_new;
                    sign_a_d = src_a[WIDTH-1];
                    neg_d    = src_a[WIDTH-1] ^ src_b[WIDTH-1];
                    acc_d    = '0;
                    qp_d     = start_mult ? b_mag_new[WIDTH-1:0] : a_mag_new[WIDTH-1:0];
                    dz_d     = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!op_div_q) begin
                        acc_d = {1'b0, add_sum[WIDTH:1]};
                        qp_d  = {add_sum[0], qp_q[WIDTH-1:1]};
                    end else if (trial >= b_mag_q) begin
                        acc_d = sub_diff;
                        qp_d  = {qp_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = trial;
                        qp_d  = {qp_q[WIDTH-2:0], 1'b0};
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (!op_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (b_mag_q == '0) begin
                        lo_d = '1;
                        hi_d = a_orig;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            qp_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            qp_q     <= qp_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            op_div_q <= op_div_d;
            neg_q    <= neg_d;
            sign_a_q <= sign_a_d;
            dz_q     <= dz_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign dz    = dz_q;
    assign busy  = (state_q == S_ITER) || (state_q == S_FIX);
    assign done  = (state_q == S_DONE);
    assign stall = (mf_req || start_mult || start_div) && busy;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq against a signed arithmetic model
module tb_muldiv_seq;
    localparam int W = 32;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n, start_mult, start_div, flush, mf_req;
    logic [W-1:0] src_a, src_b;
    logic [W-1:0] hi, lo;
    logic         busy, done, stall, dz;

    int           errs = 0;
    int           checks = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dz = 1'b0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_mult(start_mult), .start_div(start_div),
        .flush(flush), .mf_req(mf_req), .src_a(src_a), .src_b(src_b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] mh, output logic [W-1:0] ml, output logic mdz);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        mdz = 1'b0;
        if (!is_div) begin
            p  = sa * sb;
            mh = p[2*W-1:W];
            ml = p[W-1:0];
        end else if (b == '0) begin
            mh  = a;
            ml  = '1;
            mdz = 1'b1;
        end else begin
            p  = sa / sb;
            ml = p[W-1:0];
            p  = sa % sb;
            mh = p[W-1:0];
        end
    endtask

    task automatic drive_start(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
        start_mult = !is_div;
        start_div  = is_div;
        src_a      = a;
        src_b      = b;
    endtask

    // Expects the start already driven; returns on a falling edge.
    task automatic do_op(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit chain, input bit n_div, input logic [W-1:0] na, input logic [W-1:0] nb);
        logic [W-1:0] mh, ml;
        logic mdz;
        model(is_div, a, b, mh, ml, mdz);
        @(posedge clk);
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        exp_dz     = 1'b0;
        for (int k = 0; k <= W + 1; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (k <= W) begin
                if (busy !== 1'b1 || done !== 1'b0 || dz !== exp_dz || hi !== exp_hi || lo !== exp_lo) begin
                    errs++;
                    $display("FAIL op_running k=%0d: busy=%b done=%b dz=%b hi=%h lo=%h, required busy=1 done=0 dz=%b hi=%h lo=%h",
                             k, busy, done, dz, hi, lo, exp_dz, exp_hi, exp_lo);
                end
            end else begin
                exp_hi = mh;
                exp_lo = ml;
                exp_dz = mdz;
                if (busy !== 1'b0 || done !== 1'b1 || dz !== exp_dz || hi !== exp_hi || lo !== exp_lo) begin
                    errs++;
                    $display("FAIL op_result div=%b a=%h b=%h: busy=%b done=%b dz=%b hi=%h lo=%h, required busy=0 done=1 dz=%b hi=%h lo=%h",
                             is_div, a, b, busy, done, dz, hi, lo, exp_dz, exp_hi, exp_lo);
                end
            end
        end
        if (chain) begin
            drive_start(n_div, na, nb);
        end else begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errs++;
                $display("FAIL done_one_cycle: done=%b busy=%b, required done=0 busy=0", done, busy);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_mult = 1'b1; start_div = 1'b0; flush = 1'b0; mf_req = 1'b1;
        src_a = 32'd5; src_b = 32'd6;
        #12;
        checks++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0 || stall !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b stall=%b, required all zero",
                     hi, lo, busy, done, dz, stall);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        mf_req = 1'b0;
        drive_start(1'b0, 32'd5, 32'hFFFF_FFFA);
        do_op(1'b0, 32'd5, 32'hFFFF_FFFA, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_directed;
        @(negedge clk); drive_start(1'b0, 32'd7, 32'hFFFF_FFFD);
        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, '0, '0);
        @(negedge clk); drive_start(1'b1, 32'hFFFF_FFF9, 32'd2);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, '0);
        @(negedge clk); drive_start(1'b1, 32'h1234_5678, 32'd0);
        do_op(1'b1, 32'h1234_5678, 32'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk); drive_start(1'b0, 32'd100, 32'd3);
        do_op(1'b0, 32'd100, 32'd3, 1'b0, 1'b0, '0, '0);
        @(negedge clk); drive_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, '0);
        @(negedge clk); drive_start(1'b0, 32'h8000_0000, 32'h8000_0000);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '0, '0);
        @(negedge clk); drive_start(1'b0, 32'hFFFF_FFF0, 32'd9);
        start_div = 1'b1;
        do_op(1'b0, 32'hFFFF_FFF0, 32'd9, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back;
        @(negedge clk); drive_start(1'b1, 32'd1000, 32'hFFFF_FFF9);
        do_op(1'b1, 32'd1000, 32'hFFFF_FFF9, 1'b1, 1'b0, 32'd123, 32'd456);
        do_op(1'b0, 32'd123, 32'd456, 1'b1, 1'b1, 32'd77, 32'd0);
        do_op(1'b1, 32'd77, 32'd0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_stall;
        logic [W-1:0] mh, ml;
        logic mdz;
        model(1'b1, 32'd1000, 32'd7, mh, ml, mdz);
        @(negedge clk); drive_start(1'b1, 32'd1000, 32'd7);
        @(posedge clk);
        for (int k = 0; k <= W + 1; k++) begin
            @(negedge clk);
            start_div = 1'b0;
            start_mult = 1'b0;
            mf_req = 1'b1;
            if (k == 4) drive_start(1'b1, 32'd55, 32'd5);
            checks++;
            if (k <= W && stall !== 1'b1) begin
                errs++;
                $display("FAIL stall_busy k=%0d: stall=%b, required 1", k, stall);
            end else if (k == W + 1 && (stall !== 1'b0 || done !== 1'b1 || hi !== mh || lo !== ml)) begin
                errs++;
                $display("FAIL stall_done: stall=%b done=%b hi=%h lo=%h, required stall=0 done=1 hi=%h lo=%h",
                         stall, done, hi, lo, mh, ml);
            end
        end
        exp_hi = mh; exp_lo = ml; exp_dz = mdz;
        mf_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush;
        bit saw_done;
        @(negedge clk); drive_start(1'b0, 32'd999, 32'd888);
        @(posedge clk);
        @(negedge clk);
        start_mult = 1'b0;
        exp_dz = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo || dz !== exp_dz) begin
            errs++;
            $display("FAIL flush_busy: busy=%b hi=%h lo=%h dz=%b, required busy=0 hi=%h lo=%h dz=%b",
                     busy, hi, lo, dz, exp_hi, exp_lo, exp_dz);
        end
        saw_done = 1'b0;
        for (int k = 0; k < W + 8; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errs++;
            $display("FAIL flush_no_done: done or hi/lo changed after flush, required none");
        end
        drive_start(1'b1, 32'd1, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start_div = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL flush_idle_start: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_random;
        bit           d[N], ch[N];
        logic [W-1:0] ra[N], rb[N];
        bit           chain;
        int           nx;
        for (int i = 0; i < N; i++) begin
            d[i]  = 1'($urandom_range(0, 1));
            ch[i] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: begin ra[i] = $urandom; rb[i] = '0; end
                1: begin ra[i] = 32'h8000_0000; rb[i] = 32'hFFFF_FFFF; end
                2: begin ra[i] = $urandom_range(0, 40) - 32'd20; rb[i] = $urandom_range(0, 40) - 32'd20; end
                default: begin ra[i] = $urandom; rb[i] = $urandom; end
            endcase
        end
        @(negedge clk); drive_start(d[0], ra[0], rb[0]);
        for (int i = 0; i < N; i++) begin
            nx    = (i < N - 1) ? i + 1 : i;
            chain = (i < N - 1) && ch[i];
            do_op(d[i], ra[i], rb[i], chain, d[nx], ra[nx], rb[nx]);
            if (!chain && i < N - 1) drive_start(d[nx], ra[nx], rb[nx]);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); drive_start(1'b1, 32'hDEAD_BEEF, 32'd13);
        @(posedge clk);
        @(negedge clk);
        start_div = 1'b0;
        for (int k = 1; k <= 19; k++) @(negedge clk);
        mf_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        checks++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0 || stall !== 1'b0) begin
            errs++;
            $display("FAIL reset_async: hi=%h lo=%h busy=%b done=%b dz=%b stall=%b, required all zero",
                     hi, lo, busy, done, dz, stall);
        end
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errs++;
            $display("FAIL reset_no_done: done=%b, required 0", done);
        end
        rst_n  = 1'b1;
        mf_req = 1'b0;
        drive_start(1'b0, 32'd3, 32'd4);
        do_op(1'b0, 32'd3, 32'd4, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_stall;
        test_flush;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
